itof_arb: RTL and testbench

- Shares one combinational `itof` converter (signed int32 to float32) between NREQ requesters, e.g. integer and FPU issue ports.
- Round-robin arbitration feeds a 2-stage registered pipeline (operand register, then result register) with valid/ready handshakes.
- Each result returns tagged with the requester index.
- Sits between the issue logic and the FPU writeback arbiter.

---
 rtl/itof_arb.sv | 127 ++++++++++++
 tb/tb_itof_arb.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/itof_arb.sv
// Shared int32->float32 converter with round-robin arbitration and a two-stage
// valid/ready pipeline. Define ITOF_ARB_STAT_EN to add handshake/stall counters.
module itof_arb #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [32*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              res_valid,
  output logic [31:0]       res_data,
  output logic [IDW-1:0]    res_id,
  input  logic              res_ready
`ifdef ITOF_ARB_STAT_EN
  ,
  output logic [31:0]       stat_conv,
  output logic [31:0]       stat_stall
`endif
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; a producer holds valid and data steady until that edge.

  // Magnitude is normalised so its leading one sits at bit 31, then rounded
  // half-up at bit 7; a carry out of the significand bumps the exponent.
  function automatic logic [31:0] itof(input logic [31:0] a);
    logic        sign;
    logic [31:0] mag;
    logic [31:0] norm;
    logic [4:0]  msb;
    logic [24:0] rnd;
    logic [7:0]  expo;
    sign = a[31];
    mag  = sign ? (~a + 32'd1) : a;
    msb  = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = i[4:0];
    end
    norm = mag << (5'd31 - msb);
    rnd  = {1'b0, norm[31:8]} + {24'd0, norm[7]};
    expo = 8'd127 + {3'd0, msb} + {7'd0, rnd[24]};
    if (mag == 32'd0) itof = 32'd0;
    else              itof = {sign, expo, rnd[24] ? 23'd0 : rnd[22:0]};
  endfunction

  logic           s1_valid;
  logic [31:0]    s1_data;
  logic [IDW-1:0] s1_id;
  logic           s2_valid;
  logic [31:0]    s2_data;
  logic [IDW-1:0] s2_id;
  logic [IDW-1:0] rr_ptr;

  logic           adv1;
  logic           adv2;
  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [31:0]    grant_data;
  logic [IDW-1:0] rr_next;
  int             idx;

  assign adv2 = !s2_valid || res_ready;
  assign adv1 = !s1_valid || adv2;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant_data  = '0;
    idx         = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx[IDW-1:0];
        grant_data  = req_data[32*idx +: 32];
      end
    end
    rr_next = IDW'((int'(grant_idx) + 1) % NREQ);
    // rstn gating keeps the grant silent while the pipeline is held in reset.
    req_ready = (adv1 && grant_found && rstn) ? (NREQ'(1) << grant_idx) : '0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_id    <= '0;
      rr_ptr   <= '0;
    end else begin
      if (adv2) begin
        s2_valid <= s1_valid;
        s2_data  <= itof(s1_data);
        s2_id    <= s1_id;
      end
      if (adv1) begin
        s1_valid <= grant_found;
        if (grant_found) begin
          s1_data <= grant_data;
          s1_id   <= grant_idx;
          rr_ptr  <= rr_next;
        end
      end
    end
  end

  assign res_valid = s2_valid;
  assign res_data  = s2_data;
  assign res_id    = s2_id;

`ifdef ITOF_ARB_STAT_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_conv  <= '0;
      stat_stall <= '0;
    end else begin
      if (s2_valid && res_ready)  stat_conv  <= stat_conv + 32'd1;
      if (s2_valid && !res_ready) stat_stall <= stat_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_itof_arb.sv
// Bench for itof_arb: randomized and directed traffic, reference arbiter and
// converter model, expected-result queue popped by a monitor on each result.
module tb_itof_arb;
  localparam int NREQ = 2;
  localparam int IDW  = 2;
  localparam int EW   = IDW + 32;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [NREQ-1:0]      req_valid = '0;
  logic [32*NREQ-1:0]   req_data = '0;
  logic [NREQ-1:0]      req_ready;
  logic                 res_valid;
  logic [31:0]          res_data;
  logic [IDW-1:0]       res_id;
  logic                 res_ready = 1'b1;
`ifdef ITOF_ARB_STAT_EN
  logic [31:0]          stat_conv;
  logic [31:0]          stat_stall;
`endif

  itof_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id),
    .res_ready(res_ready)
`ifdef ITOF_ARB_STAT_EN
    , .stat_conv(stat_conv), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] res_log[$];
  int            res_cyc[$];
  logic [31:0]   pend_q[NREQ][$];
  logic [NREQ-1:0] acc_mask = '0;
  int            gap_pct = 0;
  bit            rand_ready = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference conversion: scale the magnitude into [2^23, 2^24) with half-up rounding.
  function automatic logic [31:0] ref_itof(input logic [31:0] a);
    logic [63:0] mag, q;
    int sh, e;
    logic s;
    s = a[31];
    mag = s ? (64'h1_0000_0000 - {32'd0, a}) : {32'd0, a};
    if (mag == 0) return 32'd0;
    sh = 0;
    while ((mag >> sh) >= (64'd1 << 24)) sh++;
    q = (sh > 0) ? ((mag + (64'd1 << (sh - 1))) >> sh) : mag;
    e = sh;
    if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
    while (q < (64'd1 << 23)) begin q = q << 1; e--; end
    return {s, 8'(127 + 23 + e), 23'(q - (64'd1 << 23))};
  endfunction

  // Monitor: reference arbiter (round-robin over a two-deep pipeline) plus scoreboard.
  int m_ptr, m_cnt, cyc, g, ix;
  int m_conv, m_stall;
  logic [NREQ-1:0] exp_rdy;
  bit prev_stall;
  logic [31:0] prev_data;
  logic [IDW-1:0] prev_id;
  logic [EW-1:0] exp_e;

  initial begin
    m_ptr = 0; m_cnt = 0; cyc = 0; m_conv = 0; m_stall = 0; prev_stall = 0;
    prev_data = '0; prev_id = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        exp_q.delete();
        m_ptr = 0; m_cnt = 0; m_conv = 0; m_stall = 0;
        prev_stall = 0; acc_mask = '0;
        continue;
      end
      exp_rdy = '0; g = 0;
      if (m_cnt < 2 || res_ready) begin
        for (int k = 0; k < NREQ; k++) begin
          ix = (m_ptr + k) % NREQ;
          if (exp_rdy == '0 && req_valid[ix]) begin
            exp_rdy[ix] = 1'b1;
            g = ix;
          end
        end
      end
      check("req_ready", 64'(req_ready), 64'(exp_rdy));
      if (prev_stall) begin
        check("stall res_valid", 64'(res_valid), 64'd1);
        check("stall res_data", 64'(res_data), 64'(prev_data));
        check("stall res_id", 64'(res_id), 64'(prev_id));
      end
`ifdef ITOF_ARB_STAT_EN
      check("stat_conv", 64'(stat_conv), 64'(m_conv));
      check("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected result", 64'(res_valid), 64'd0);
        end else begin
          exp_e = exp_q.pop_front();
          check("result", 64'({res_id, res_data}), 64'(exp_e));
        end
        res_log.push_back({res_id, res_data});
        res_cyc.push_back(cyc);
        m_conv++;
      end
      if (res_valid && !res_ready) m_stall++;
      acc_mask = req_valid & req_ready;
      if (exp_rdy != '0) begin
        exp_q.push_back({IDW'(g), ref_itof(req_data[32*g +: 32])});
        m_ptr = (g + 1) % NREQ;
      end
      m_cnt = m_cnt + ((exp_rdy != '0) ? 1 : 0) - ((res_valid && res_ready) ? 1 : 0);
      prev_stall = res_valid && !res_ready;
      prev_data = res_data;
      prev_id = res_id;
    end
  end

  // Driver: called once per cycle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i] && acc_mask[i]) req_valid[i] = 1'b0;
      if (!req_valid[i] && pend_q[i].size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
        req_data[32*i +: 32] = pend_q[i].pop_front();
        req_valid[i] = 1'b1;
      end
    end
    if (rand_ready) res_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (!(pend_q[0].size() == 0 && pend_q[1].size() == 0 && req_valid == '0 &&
             exp_q.size() == 0 && !res_valid)) begin
      step();
      n++;
      if (n > 3000) begin
        n_checks++; n_fail++;
        $display("FAIL timeout %s: pending %0d results, required 0", name, exp_q.size());
        break;
      end
    end
  endtask

  task automatic do_reset();
    step();
    rstn = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    repeat (3) step();
    rstn = 1'b1;
  endtask

  function automatic logic [31:0] rand_op();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return ($urandom_range(0, 1) != 0) ? 32'($urandom_range(0, 255)) : -32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  logic [31:0] sweep_in [7] = '{32'd0, 32'hFFFF_FFFF, 32'd3, 32'd100, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h8000_0000};
  logic [31:0] sweep_out[7] = '{32'h0000_0000, 32'hBF80_0000, 32'h4040_0000, 32'h42C8_0000, 32'hC000_0000, 32'h4F00_0000, 32'hCF00_0000};
  logic [31:0] bp_ops[4];
  int base, n;

  initial begin
    // Reset state, with requests pending to show grants stay off.
    req_valid = '1;
    req_data = {32'd7, 32'd5};
    #12;
    check("reset res_valid", 64'(res_valid), 64'd0);
    check("reset res_data", 64'(res_data), 64'd0);
    check("reset res_id", 64'(res_id), 64'd0);
    check("reset req_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    step();
    rstn = 1'b1;

    // Single operation latency.
    step();
    req_valid[0] = 1'b1;
    req_data[31:0] = 32'd1;
    @(negedge clk);
    check("single req_ready", 64'(req_ready), 64'd1);
    step();
    @(negedge clk);
    check("single early res_valid", 64'(res_valid), 64'd0);
    @(negedge clk);
    check("single res_valid", 64'(res_valid), 64'd1);
    check("single res_data", 64'(res_data), 64'h3F80_0000);
    check("single res_id", 64'(res_id), 64'd0);
    wait_idle("single");

    // Value sweep on requester 1.
    base = res_log.size();
    for (int k = 0; k < 7; k++) pend_q[1].push_back(sweep_in[k]);
    wait_idle("sweep");
    check("sweep count", 64'(res_log.size() - base), 64'd7);
    for (int k = 0; k < 7 && base + k < res_log.size(); k++) begin
      check("sweep data", 64'(res_log[base+k][31:0]), 64'(sweep_out[k]));
      check("sweep id", 64'(res_log[base+k][EW-1:32]), 64'd1);
    end

    // Fairness from a fresh reset.
    do_reset();
    @(negedge clk);
    base = res_log.size();
    for (int k = 0; k < 3; k++) begin
      pend_q[0].push_back(32'(100 + k));
      pend_q[1].push_back(-32'(200 + k));
    end
    wait_idle("fair");
    check("fair count", 64'(res_log.size() - base), 64'd6);
    for (int k = 0; k < 6 && base + k < res_log.size(); k++) begin
      check("fair id", 64'(res_log[base+k][EW-1:32]), 64'(k % 2));
      if (k > 0) check("fair spacing", 64'(res_cyc[base+k] - res_cyc[base+k-1]), 64'd1);
    end

    // Backpressure: 3 stalled cycles after the first result.
    do_reset();
    base = res_log.size();
    for (int k = 0; k < 4; k++) begin
      bp_ops[k] = rand_op();
      pend_q[0].push_back(bp_ops[k]);
    end
    n = 0;
    while (res_log.size() == base && n < 50) begin step(); n++; end
    check("bp first result", 64'(res_log.size() > base), 64'd1);
    res_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp req_ready", 64'(req_ready), 64'd0);
      step();
    end
    res_ready = 1'b1;
    wait_idle("bp");
    check("bp count", 64'(res_log.size() - base), 64'd4);
    for (int k = 0; k < 4 && base + k < res_log.size(); k++)
      check("bp result", 64'(res_log[base+k]), 64'({IDW'(0), ref_itof(bp_ops[k])}));
`ifdef ITOF_ARB_STAT_EN
    @(negedge clk);
    check("bp stat_conv", 64'(stat_conv), 64'd4);
    check("bp stat_stall", 64'(stat_stall), 64'd3);
`endif

    // Randomized traffic with random gaps and backpressure.
    gap_pct = 40;
    rand_ready = 1;
    for (int k = 0; k < 300; k++) pend_q[$urandom_range(0, NREQ-1)].push_back(rand_op());
    n = 0;
    while ((pend_q[0].size() != 0 || pend_q[1].size() != 0) && n < 5000) begin step(); n++; end
    rand_ready = 0;
    gap_pct = 0;
    res_ready = 1'b1;
    wait_idle("random");

    // Reset while both stages hold operations.
    res_ready = 1'b0;
    pend_q[0].push_back(32'd11);
    pend_q[0].push_back(32'd22);
    repeat (6) step();
    @(negedge clk);
    check("pre-reset res_valid", 64'(res_valid), 64'd1);
    #2;
    rstn = 1'b0;
    #1;
    check("async res_valid", 64'(res_valid), 64'd0);
    check("async res_data", 64'(res_data), 64'd0);
    check("async res_id", 64'(res_id), 64'd0);
    req_valid = '1;
    req_data = {32'd9, 32'd8};
    #1;
    check("in-reset req_ready", 64'(req_ready), 64'd0);
    repeat (2) step();
    rstn = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    check("post-reset grant", 64'(req_ready), 64'd1);
    check("post-reset res_valid", 64'(res_valid), 64'd0);
    step();
    @(negedge clk);
    check("no stale result", 64'(res_valid), 64'd0);
    wait_idle("post-reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL global timeout: simulation time exceeded, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $fatal(1);
  end

endmodule
